// File: rtl/eth_phy_rst_ctrl.sv
// Ethernet PHY reset sequencer: timed reset pulse, post-release hold-off,
// ready indication, soft and link-loss watchdog re-resets.
module eth_phy_rst_ctrl #(
    parameter int ASSERT_CYCLES  = 1250000,
    parameter int RELEASE_CYCLES = 6250000,
    parameter int LINK_TO_CYCLES = 12500000,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_rst_req,
    input  logic       link_up,
    input  logic       link_to_en,
    output logic       phy_rst_n,
    output logic       phy_ready,
    output logic       busy,
    output logic [1:0] last_cause,
    output logic [7:0] rst_cnt
);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_HOLDOFF = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_SOFT = 2'b01;
    localparam logic [1:0] CAUSE_LINK = 2'b10;

    localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LINK_LAST    = CNT_W'(LINK_TO_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [7:0]       rcnt_q, rcnt_d;
    logic             phy_rst_n_q, phy_rst_n_d;
    logic             phy_ready_q, phy_ready_d;
    logic             busy_q, busy_d;

    logic             wdog_hit;
    logic [7:0]       rcnt_inc;

    assign rcnt_inc = (rcnt_q == 8'hFF) ? rcnt_q : rcnt_q + 8'd1;
    assign wdog_hit = link_to_en && !link_up && (lcnt_q == LINK_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lcnt_d  = '0;
        cause_d = cause_q;
        rcnt_d  = rcnt_q;

        unique case (state_q)
            ST_ASSERT: begin
                // Requests during the pulse are dropped, not queued
                if (cnt_q == ASSERT_LAST) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (soft_rst_req) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    cause_d = CAUSE_SOFT;
                    rcnt_d  = rcnt_inc;
                end else if (cnt_q == RELEASE_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READY: begin
                if (link_to_en && !link_up) begin
                    lcnt_d = lcnt_q + CNT_W'(1);
                end
                // Soft request wins the cause when both fire together
                if (soft_rst_req || wdog_hit) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    lcnt_d  = '0;
                    cause_d = soft_rst_req ? CAUSE_SOFT : CAUSE_LINK;
                    rcnt_d  = rcnt_inc;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
            end
        endcase

        if (rst) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            lcnt_d  = '0;
            cause_d = CAUSE_POR;
            rcnt_d  = '0;
        end
    end

    always_comb begin
        phy_rst_n_d = (state_d != ST_ASSERT);
        phy_ready_d = (state_d == ST_READY);
        busy_d      = (state_d != ST_READY);
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        lcnt_q      <= lcnt_d;
        cause_q     <= cause_d;
        rcnt_q      <= rcnt_d;
        phy_rst_n_q <= phy_rst_n_d;
        phy_ready_q <= phy_ready_d;
        busy_q      <= busy_d;
    end

    assign phy_rst_n  = phy_rst_n_q;
    assign phy_ready  = phy_ready_q;
    assign busy       = busy_q;
    assign last_cause = cause_q;
    assign rst_cnt    = rcnt_q;

endmodule
